// File: rtl/scale_rr_pkg.sv
// Shared types and constants for the round-robin shift-add constant scaler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package scale_rr_pkg;

    // Default operand/result width (sign-magnitude: bit W-1 sign, W-2:0 magnitude)
    localparam int W_DEF = 32;

    // Standard gain constant loaded into the coefficient mask at reset
    localparam logic [31:0] COEF_RST_DEF = 32'h1B5C_A2B4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a requester index; a single requester still gets one bit
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scale_rr_seq_rr_arb.sv
// N-way round-robin arbiter: first asserted request at or after ptr wins.
// Latency: purely combinational, no registers (pointer is held by the parent).
// Backpressure: none; grant simply follows the request vector.
//
// Ports: req  - request vector
//        ptr  - index searched first
//        gnt  - one-hot grant (all zero when no request)
//        idx  - encoded index of the granted requester
//        any  - at least one request is pending
module rr_arb #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        // Walk the requesters in rotated order; the first hit locks out the rest
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/scale_rr_seq.sv
// Time-shared serial shift-add constant scaler for NREQ round-robin requesters.
// Latency: out_valid rises 32 cycles after the accept edge; one job at a time.
// Backpressure: result holds in DONE while out_ready is low; no accepts meanwhile.
//
// Ports: req_valid/req_data/req_ready - per-requester operand handshake
//        out_valid/out_ready/out_data/out_id - tagged result handshake
//        cfg_we/cfg_mask - coefficient mask write (any state)
//        busy - high outside IDLE
module scale_rr_seq
    import scale_rr_pkg::*;
#(
    parameter int          W        = W_DEF,
    parameter int          NREQ     = 2,
    parameter logic [31:0] COEF_RST = COEF_RST_DEF,
    localparam int         IDW      = id_w(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [IDW-1:0]    out_id,
    input  logic              cfg_we,
    input  logic [31:0]       cfg_mask,
    output logic              busy
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [31:0]     coef_reg;

    // Job registers, captured on the accept edge
    logic [31:0]     job_mask;
    logic            job_sign;
    logic [W-2:0]    job_mag;
    logic [IDW-1:0]  job_id;

    logic [W-1:0]    acc;
    logic            ovf;
    logic [4:0]      k;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic            accept;
    logic [W-1:0]    sel_data;
    logic [W-1:0]    term;
    logic [W:0]      sum;

    rr_arb #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign accept    = (state == IDLE) && gnt_any;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) sel_data = req_data[i*W +: W];
        end
    end

    // Shifts of W-1 or more leave nothing of the magnitude, so they add zero
    always_comb begin
        term = '0;
        if (job_mask[k] && (int'(k) < W - 1)) term = {1'b0, job_mag >> k};
    end

    // One extra bit so a carry out of the guard bit is never lost
    assign sum = {1'b0, acc} + {1'b0, term};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            coef_reg <= COEF_RST;
            job_mask <= '0;
            job_sign <= 1'b0;
            job_mag  <= '0;
            job_id   <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            k        <= '0;
        end else begin
            // The accept branch below reads the pre-write coef_reg, so a write
            // landing on the accept edge only affects the following job.
            if (cfg_we) coef_reg <= cfg_mask;

            case (state)
                IDLE: begin
                    if (accept) begin
                        job_mask <= coef_reg;
                        job_sign <= sel_data[W-1];
                        job_mag  <= sel_data[W-2:0];
                        job_id   <= gnt_idx;
                        acc      <= '0;
                        ovf      <= 1'b0;
                        k        <= '0;
                        if (int'(gnt_idx) == NREQ - 1) ptr <= '0;
                        else                           ptr <= gnt_idx + 1'b1;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    acc <= sum[W-1:0];
                    // Anything reaching the guard bit exceeds the magnitude range
                    if (sum[W] || sum[W-1]) ovf <= 1'b1;
                    k <= k + 5'd1;
                    if (k == 5'd31) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign out_data  = out_valid ? {job_sign, ovf ? {(W-1){1'b1}} : acc[W-2:0]} : '0;
    assign out_id    = out_valid ? job_id : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_scale_rr_seq.sv
// Self-checking bench for scale_rr_seq (directed steps plus random operands).
// Latency: checks accept-to-out_valid distance of 32 edges.
// Backpressure: exercises out_ready held low and the resulting stall.
module tb_scale_rr_seq;
    import scale_rr_pkg::*;

    localparam int NREQ = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0] req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [0:0]      out_id;
    logic            cfg_we;
    logic [31:0]     cfg_mask;
    logic            busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] cur_mask;

    always #5 clk = ~clk;

    scale_rr_seq #(.W(32), .NREQ(NREQ), .COEF_RST(32'h1B5C_A2B4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .cfg_we    (cfg_we),
        .cfg_mask  (cfg_mask),
        .busy      (busy)
    );

    // Reference: sum of independently truncated terms, then clamp to 31 bits
    function automatic logic [31:0] golden(input logic [31:0] op, input logic [31:0] m);
        longint unsigned s;
        longint unsigned mg;
        s  = 0;
        mg = longint'(op[30:0]);
        for (int kk = 0; kk < 32; kk++) begin
            if (m[kk] && kk < 31) s += mg >> kk;
        end
        if (s > 64'h7FFF_FFFF) return {op[31], 31'h7FFF_FFFF};
        return {op[31], s[30:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mask(input logic [31:0] m);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_mask = m;
        @(negedge clk);
        cfg_we   = 1'b0;
        cur_mask = m;
    endtask

    // One complete job from a single requester with out_ready high
    task automatic job(input int r, input logic [31:0] d, input logic [31:0] exp, input string tag);
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        req_data[r*32 +: 32] = d;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_rdy"}, 64'(req_ready), 64'(1 << r));
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd32);
        chk({tag, "_data"}, 64'(out_data), 64'(exp));
        chk({tag, "_id"}, 64'(out_id), 64'(r));
        @(posedge clk); #1;
        chk({tag, "_drop"}, 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur_mask = 32'h1B5C_A2B4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] exp;
        logic [31:0] rr_dat [2];
        int n;
        int seen;
        int eg;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_mask  = '0;
        cur_mask  = 32'h1B5C_A2B4;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_data",  64'(out_data), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Default gain constant, sign handling and zero-magnitude truncation
        job(0, 32'h4000_0000, 32'h16A2_9D6C, "def_pos");
        job(0, 32'hC000_0000, 32'h96A2_9D6C, "def_neg");
        job(1, 32'h8000_0001, 32'h8000_0000, "def_trunc");
        job(1, 32'h8000_0000, 32'h8000_0000, "neg_zero");

        for (int i = 0; i < 500; i++) begin
            d = $urandom;
            job(int'($urandom_range(0, 1)), d, golden(d, cur_mask), "rand");
        end

        // Runtime masks: identity, saturation, two-term sum
        set_mask(32'h0000_0001);
        job(0, 32'h8000_1234, 32'h8000_1234, "m1");
        set_mask(32'h0000_0003);
        job(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "m3_sat");
        job(0, 32'h4000_0000, 32'h6000_0000, "m3_sum");

        // Both requesters held from reset: alternating grants, mid-job mask write
        do_reset();
        rr_dat[0] = 32'h4000_0000;
        rr_dat[1] = 32'h0000_1234;
        @(negedge clk);
        req_data  = {rr_dat[1], rr_dat[0]};
        req_valid = 2'b11;
        out_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            eg = j % 2;
            n = 0;
            while (req_ready === '0 && n < 100) begin
                @(posedge clk); #1; n++;
            end
            chk("rr_gnt", 64'(req_ready), 64'(1 << eg));
            exp = golden(rr_dat[eg], cur_mask);
            @(posedge clk); #1;
            chk("rr_1cyc", 64'(req_ready), 64'd0);
            if (j == 1) begin
                @(negedge clk);
                cfg_we   = 1'b1;
                cfg_mask = 32'h0000_0001;
                @(negedge clk);
                cfg_we   = 1'b0;
                cur_mask = 32'h0000_0001;
            end
            n = 0;
            while (out_valid !== 1'b1 && n < 100) begin
                @(posedge clk); #1; n++;
            end
            chk("rr_id", 64'(out_id), 64'(eg));
            chk("rr_data", 64'(out_data), 64'(exp));
            @(posedge clk); #1;
        end
        req_valid = '0;

        // Back-pressure: hold DONE for 10 cycles with another request waiting
        @(negedge clk);
        out_ready = 1'b0;
        req_data[31:0] = 32'h4000_0000;
        req_valid[0] = 1'b1;
        #1;
        chk("bp_rdy", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        req_valid[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data",  64'(out_data), 64'h4000_0000);
            chk("bp_id",    64'(out_id), 64'd0);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_busy",  64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_valid", 64'(out_valid), 64'd0);
        chk("bp_rel_busy",  64'(busy), 64'd0);
        chk("bp_rel_ready", 64'(req_ready), 64'd2);
        req_valid[1] = 1'b0;

        // Reset mid-job at k=15 after changing the mask and moving the pointer
        set_mask(32'h0000_0003);
        @(negedge clk);
        req_data[31:0] = 32'h4000_0000;
        req_valid[0] = 1'b1;
        #1;
        chk("mr_rdy", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_busy",  64'(busy), 64'd0);
        chk("mr_data",  64'(out_data), 64'd0);
        chk("mr_id",    64'(out_id), 64'd0);
        chk("mr_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_mask = 32'h1B5C_A2B4;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("mr_no_out", 64'(seen), 64'd0);
        req_valid = 2'b11;
        #1;
        chk("mr_ptr", 64'(req_ready), 64'd1);
        req_valid = '0;
        job(0, 32'h4000_0000, 32'h16A2_9D6C, "mr_mask");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
